// File: rtl/piece_controller.sv
// piece_controller: owns the falling tetromino (type, rotation, origin, gravity, moves)
// and runs the lock/spawn handshake with the board.
module piece_controller #(
   parameter int GRAVITY_FRAMES = 30,
   parameter int SPAWN_X = 3,
   parameter int SPAWN_Y = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk_rising_edge,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        key_rot_l,
   input  logic        key_rot_r,
   input  logic        key_down,
   input  logic [4:0]  can_move,
   input  logic        BOARD_BUSY,
   input  logic [2:0]  next_type,
   output logic [19:0] x_block,
   output logic [19:0] y_block,
   output logic [19:0] save_xblock,
   output logic [19:0] save_yblock,
   output logic [19:0] x_move_left,
   output logic [19:0] x_move_right,
   output logic [19:0] x_move_down,
   output logic [19:0] x_rotate_left,
   output logic [19:0] x_rotate_right,
   output logic [19:0] y_move_left,
   output logic [19:0] y_move_right,
   output logic [19:0] y_move_down,
   output logic [19:0] y_rotate_left,
   output logic [19:0] y_rotate_right,
   output logic        get_new_block,
   output logic [2:0]  block,
   output logic        game_over
);
   typedef enum logic [1:0] {SPAWN, FALL, LOCK, OVER} state_t;
   state_t state, state_nx;
   logic [2:0]  piece_type;
   logic [1:0]  rot;
   logic [4:0]  ox, oy, keys, pend, req, sel;
   logic [7:0]  cnt;
   logic        moved, frame, due, go_down, commit, down_fail;
   logic [19:0] sx, sy;
   logic [39:0] cur;

   // Packed {x0..x3, y0..y3}; offsets rotated clockwise r times about an N x N box.
   function automatic logic [39:0] cells(input logic [2:0] t, input logic [1:0] r,
                                         input logic [4:0] x, input logic [4:0] y);
      logic [39:0] c;
      logic [15:0] s;
      logic [1:0]  m, dx, dy, tmp;
      c = '0;
      s = t == 3'd1 ? 16'h0415 : t == 3'd2 ? 16'h4159 : t == 3'd3 ? 16'h4815 :
          t == 3'd4 ? 16'h0459 : t == 3'd5 ? 16'h0159 : t == 3'd6 ? 16'h8159 : 16'h159D;
      m = t == 3'd1 ? 2'd1 : (t == 3'd0 || t == 3'd7) ? 2'd3 : 2'd2;
      for (int i = 0; i < 4; i++) begin
         dx = s[15-4*i -: 2];
         dy = s[13-4*i -: 2];
         for (int k = 0; k < 3; k++)
            if (k < int'(r)) begin
               tmp = dx;
               dx = m - dy;
               dy = tmp;
            end
         c[39-5*i -: 5] = x + {3'b0, dx};
         c[19-5*i -: 5] = y + {3'b0, dy};
      end
      return c;
   endfunction

   // Bit order of keys/pend/req/sel matches can_move: left, right, rot_r, rot_l, down.
   always_comb begin
      keys = {key_left, key_right, key_rot_r, key_rot_l, key_down};
      frame = frame_clk_rising_edge && state == FALL;
      due = cnt == 8'(GRAVITY_FRAMES - 1);
      req = pend | keys;
      go_down = due | req[0];
      sel[0] = go_down;
      sel[2] = ~go_down & req[2];
      sel[1] = ~|{go_down, req[2]} & req[1];
      sel[4] = ~|{go_down, req[2:1]} & req[4];
      sel[3] = ~|{go_down, req[4], req[2:1]} & req[3];
      commit = frame && |(sel & can_move);
      down_fail = frame && sel[0] && !can_move[0];
      cur = cells(piece_type, rot, ox, oy);
   end

   always_ff @(posedge Clk)
      if (Reset) state <= SPAWN;
      else state <= state_nx;

   always_comb
      state_nx = state == SPAWN ? (BOARD_BUSY ? SPAWN : FALL) :
                 state == FALL  ? (down_fail ? LOCK : FALL) :
                 state == LOCK  ? (moved ? SPAWN : OVER) : OVER;

   always_ff @(posedge Clk)
      if (Reset) begin
         piece_type <= '0;
         rot <= '0;
         ox <= 5'(SPAWN_X);
         oy <= 5'(SPAWN_Y);
         cnt <= '0;
         pend <= '0;
         moved <= 1'b0;
         sx <= '0;
         sy <= '0;
      end else begin
         pend <= frame ? '0 : pend | keys;
         if (frame) cnt <= due ? '0 : cnt + 8'd1;
         if (state == SPAWN) moved <= 1'b0;
         if (state == SPAWN || state == LOCK) {sx, sy} <= cur;
         if (commit) begin
            {sx, sy} <= cur;
            if (sel[0]) begin
               oy <= oy + 5'd1;
               moved <= 1'b1;
            end
            rot <= sel[2] ? rot + 2'd1 : sel[1] ? rot - 2'd1 : rot;
            ox <= sel[4] ? ox - 5'd1 : sel[3] ? ox + 5'd1 : ox;
         end
         if (state == LOCK) begin
            piece_type <= next_type == 3'd7 ? 3'd0 : next_type;
            rot <= '0;
            ox <= 5'(SPAWN_X);
            oy <= 5'(SPAWN_Y);
         end
      end

   always_comb begin
      {x_block, y_block} = state == OVER ? {sx, sy} : cur;
      {save_xblock, save_yblock} = (state == FALL || state == OVER) ? {sx, sy} : cur;
      {x_move_left, y_move_left} = cells(piece_type, rot, ox - 5'd1, oy);
      {x_move_right, y_move_right} = cells(piece_type, rot, ox + 5'd1, oy);
      {x_move_down, y_move_down} = cells(piece_type, rot, ox, oy + 5'd1);
      {x_rotate_right, y_rotate_right} = cells(piece_type, rot + 2'd1, ox, oy);
      {x_rotate_left, y_rotate_left} = cells(piece_type, rot - 2'd1, ox, oy);
      get_new_block = state == SPAWN || state == LOCK;
      game_over = state == OVER;
      block = piece_type + 3'd1;
   end
endmodule

// File: doc/piece_controller.md
Name: piece_controller

Overview:
- Owns the active falling tetromino: type, rotation, origin, gravity timer and player moves.
- Drives the board's piece interface: current cells, previous cells, the five candidate cell sets and get_new_block.
- Consumes the board's per-move legality bits (can_move) and BOARD_BUSY.
- Runs the lock/spawn handshake so line clears never corrupt the locked or the new piece.

Parameters:
- GRAVITY_FRAMES, 30: frame edges between automatic down attempts.
- SPAWN_X, 3: origin x at spawn.
- SPAWN_Y, 0: origin y at spawn.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- frame_clk_rising_edge  in  1  one-cycle pulse per video frame.
- key_left, key_right, key_rot_l, key_rot_r, key_down  in  1 each  one-cycle key pulses from the keyboard decoder.
- can_move  in  5  legality bits from the board: [4] left, [3] right, [2] rotate right, [1] rotate left, [0] down.
- BOARD_BUSY  in  1  board is clearing, dropping or scoring.
- next_type  in  3  next piece from the randomizer (0..6; 7 is treated as 0).
- x_block, y_block  out  20  current cells. Four packed 5-bit coordinates; cell0 is [19:15].
- save_xblock, save_yblock  out  20  cells the board erases when get_new_block=0.
- x_move_left/right/down, x_rotate_left/right, y_move_left/right/down, y_rotate_left/right  out  20 each  candidate cell sets, same packing.
- get_new_block  out  1  tells the board not to erase the saved cells.
- block  out  block_color  colour of the current piece, equal to type+1 (EMPTY=0).
- game_over  out  1  sticky game-over flag.

Behaviour:
- Shape table: types I,O,T,S,Z,J,L = 0..6. Rotation-0 offsets (dx,dy), y grows downward:
  - I (0,1)(1,1)(2,1)(3,1)
  - O (0,0)(1,0)(0,1)(1,1)
  - T (1,0)(0,1)(1,1)(2,1)
  - S (1,0)(2,0)(0,1)(1,1)
  - Z (0,0)(1,0)(1,1)(2,1)
  - J (0,0)(0,1)(1,1)(2,1)
  - L (2,0)(0,1)(1,1)(2,1)
- Rotation: each clockwise step maps (dx,dy) to (N-1-dy, dx), with N=4 for I, 2 for O, 3 otherwise. Cell index order is preserved.
- Cell coordinate = origin + offset, in 5-bit unsigned arithmetic. A move left from x=0 wraps to 31; the board rejects it as out of bounds.
- Candidates are purely combinational from current registers:
  - left/right: origin x ∓1.
  - down: origin y +1.
  - rotate right/left: rot +1 / −1 mod 4.
- Pending keys: each key pulse sets a pending bit. All pending bits clear on each frame edge while in FALL; they are also cleared by Reset.
- Gravity counter: increments on each frame edge in FALL. On reaching GRAVITY_FRAMES-1 it marks gravity due and wraps to 0.
- Per frame edge in FALL, exactly one action, by priority: gravity due or pending down > rot_r > rot_l > left > right.
  - Commit when the matching can_move bit is 1 in that same cycle: save_* <= current cells, origin/rot <= candidate.
  - If a non-down action fails, nothing changes.
  - If a down action fails, go to LOCK.
- moved_down flag: cleared at spawn, set on any committed down.
- States:
  - SPAWN (reset state):
    - x/y_block = save_* = spawn cells of the current type, rot 0, origin (SPAWN_X,SPAWN_Y).
    - get_new_block=1. Held while BOARD_BUSY=1.
    - In the first cycle with BOARD_BUSY=0, go to FALL.
  - FALL: get_new_block=0; moves as above.
  - LOCK (one cycle):
    - x/y_block = save_* = locked cells, get_new_block=1; next_type is latched into type.
    - If moved_down=0 go to OVER, else go to SPAWN with rot 0 and origin at spawn.
  - OVER:
    - game_over=1, get_new_block=0; outputs frozen at the locked cells.
    - Keys are ignored. Left only by Reset.
- Reset values: type 0 (I), rot 0, origin (SPAWN_X,SPAWN_Y), state SPAWN, gravity counter 0, pending keys 0, moved_down 0, game_over 0.
  - Outputs at reset: x_block = save_xblock = {3,4,5,6}; y_block = save_yblock = {1,1,1,1}; get_new_block=1; block = type+1 = 1.
- Reset mid-operation (any state) returns to the reset values on the next edge.
- A key pulse arriving in the same cycle as a frame edge in FALL is included in that edge's action.
- Simultaneous pending keys: only the highest priority acts; the rest are discarded.

Test Plan:
1. GRAVITY_FRAMES=2, can_move=5'b11111, BOARD_BUSY=0, Reset then release.
   -> get_new_block=1 for one cycle, x_block={3,4,5,6}, y_block={1,1,1,1}.
   -> After 2 frame edges, y_block={2,2,2,2} and save_yblock={1,1,1,1}.
2. key_left pulse with can_move[4]=1 at the next frame edge -> x_block={2,3,4,5}. Repeat with can_move[4]=0 -> x_block unchanged.
3. Type T at origin (3,0), key_rot_r, can_move[2]=1 -> x_block={5,4,4,4}, y_block={1,0,1,2}. x_rotate_left shows rotation 3 before the commit.
4. After one committed down, a gravity edge with can_move[0]=0 -> LOCK for one cycle (get_new_block=1, x_block=locked cells, type<=next_type). Then SPAWN holds while BOARD_BUSY=1 for 10 cycles, and enters FALL in the first cycle with BOARD_BUSY=0.
5. Fresh piece, can_move[0]=0 at the first gravity edge -> LOCK, then game_over=1. Later key pulses and frame edges change nothing.
6. Reset asserted in FALL with pending keys and gravity counter at 1 -> next cycle in SPAWN, type 0, counter 0, no pending action at the next frame edge.
